// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-path types and constants for the I2S blocks.
//   AUDIO_SAMPLE_WIDTH / AUDIO_SLOT_WIDTH : default sample and slot sizes
//   sample_t / stereo_t                   : one channel sample / L+R pair
//   lr_for_bit()                          : word-select level for bit index b
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 24;
  localparam int AUDIO_SLOT_WIDTH   = 32;

  typedef logic signed [AUDIO_SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // LRCLK is high for b in [slot-1, 2*slot-2]. It leads each slot by one BCLK,
  // which gives the standard I2S one-bit data delay.
  function automatic logic lr_for_bit(input int unsigned b, input int unsigned slot);
    return (b >= slot - 1) && (b <= 2 * slot - 2);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample-pair handshake between the effect datapath and i2s_tx.
//   in_left/in_right : sample pair (two's complement)
//   in_valid         : pair valid (source drives)
//   in_ready         : sink can take a pair (sink drives)
//   modport master   : datapath side; modport slave : transmitter side
interface i2s_tx_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) ();

  logic [SAMPLE_WIDTH-1:0] in_left;
  logic [SAMPLE_WIDTH-1:0] in_right;
  logic                    in_valid;
  logic                    in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: bit-clock divider for the I2S blocks.
//   clk, reset : system clock, async active-high reset
//   bclk       : registered bit clock, period 2*BCLK_DIV clk
//   fall_stb   : high in the clk cycle whose edge drops bclk
//   rise_stb   : high in the clk cycle whose edge raises bclk
module i2s_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc = (cnt_q == CW'(BCLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    bclk_d = bclk_q;
    if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign fall_stb = tc &  bclk_q;
  assign rise_stb = tc & ~bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S master transmitter (DAC side).
//   clk, reset : system clock, async active-high reset
//   in_if      : slave side of the sample-pair handshake (one-pair holding buffer)
//   bclk       : bit clock, 2*BCLK_DIV clk period
//   lrclk      : word select, 0 = left, 1 = right
//   sdata      : serial data, MSB first, changes with bclk falling edge
//   underrun   : one-clk pulse when a frame starts with no buffered pair
// Build option: define I2S_TX_HOLD_EN to repeat the last transmitted pair on
// underrun; otherwise an underrun frame carries zeros.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = AUDIO_SLOT_WIDTH,
  parameter int BCLK_DIV     = 4
) (
  input  logic    clk,
  input  logic    reset,
  i2s_tx_if.slave in_if,
  output logic    bclk,
  output logic    lrclk,
  output logic    sdata,
  output logic    underrun
);

  localparam int FW   = 2 * SLOT_WIDTH;
  localparam int BW   = $clog2(FW);
  localparam int LAST = FW - 1;

  logic fall_stb, rise_stb;

  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  logic [BW-1:0]           b_q, b_d, b_next;
  logic [FW-1:0]           sr_q, sr_d, load;
  logic                    sdata_q, sdata_d;
  logic                    lrclk_q, lrclk_d;
  logic                    underrun_q, underrun_d;
  logic                    buf_full_q, buf_full_d;
  logic                    in_ready_q, in_ready_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_WIDTH-1:0] fb_l, fb_r;
  logic                    frame_start, accept;
`ifdef I2S_TX_HOLD_EN
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  // Frame image, MSB first: left slot then right slot, each sample left-justified.
  function automatic logic [FW-1:0] frame_of(input logic [SAMPLE_WIDTH-1:0] l,
                                             input logic [SAMPLE_WIDTH-1:0] r);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: SAMPLE_WIDTH]         = l;
    f[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r;
    return f;
  endfunction

  assign b_next      = (b_q == BW'(LAST)) ? '0 : b_q + BW'(1);
  assign frame_start = fall_stb && (b_q == BW'(LAST));
  assign accept      = in_if.in_valid && in_ready_q;

`ifdef I2S_TX_HOLD_EN
  assign fb_l = last_l_q;
  assign fb_r = last_r_q;
`else
  assign fb_l = '0;
  assign fb_r = '0;
`endif

  always_comb begin
    b_d        = b_q;
    sr_d       = sr_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    underrun_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    load       = '0;
`ifdef I2S_TX_HOLD_EN
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
`endif

    if (fall_stb) begin
      b_d     = b_next;
      lrclk_d = lr_for_bit(32'(b_next), SLOT_WIDTH);
      if (frame_start) begin
        if (buf_full_q) begin
          load       = frame_of(buf_l_q, buf_r_q);
          buf_full_d = 1'b0;
`ifdef I2S_TX_HOLD_EN
          last_l_d   = buf_l_q;
          last_r_d   = buf_r_q;
`endif
        end else begin
          load       = frame_of(fb_l, fb_r);
          underrun_d = 1'b1;
        end
        // The MSB goes out on the frame-start edge itself, the rest shifts later.
        sdata_d = load[FW-1];
        sr_d    = {load[FW-2:0], 1'b0};
      end else begin
        sdata_d = sr_q[FW-1];
        sr_d    = {sr_q[FW-2:0], 1'b0};
      end
    end

    // in_ready is low whenever the buffer is full, so an accept on a
    // frame-start clk only happens on the underrun path; the pair waits
    // in the buffer for the next frame.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = in_if.in_left;
      buf_r_d    = in_if.in_right;
    end

    in_ready_d = ~buf_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_q        <= BW'(LAST);
      sr_q       <= '0;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      in_ready_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
`ifdef I2S_TX_HOLD_EN
      last_l_q   <= '0;
      last_r_q   <= '0;
`endif
    end else begin
      b_q        <= b_d;
      sr_q       <= sr_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      in_ready_q <= in_ready_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
`ifdef I2S_TX_HOLD_EN
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
`endif
    end
  end

  assign sdata          = sdata_q;
  assign lrclk          = lrclk_q;
  assign underrun       = underrun_q;
  assign in_if.in_ready = in_ready_q;

  // The divider can never raise and drop bclk in the same cycle.
  strobe_excl: assert property (@(posedge clk) disable iff (reset) !(fall_stb && rise_stb));

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx (default parameters).
// Frames are captured on bclk rising edges, packed MSB-first with b=0 in bit 63.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int SW = 24;
  localparam int SL = 32;
  localparam int BD = 4;

  localparam logic [63:0] W_A  = 64'h80000100_7FFFFE00; // L=800001 R=7FFFFE
  localparam logic [63:0] W_B  = 64'hA5C3F000_0F1E2D00; // L=A5C3F0 R=0F1E2D
  localparam logic [63:0] W_C  = 64'h12345600_FEDCBA00; // L=123456 R=FEDCBA
  localparam logic [63:0] W_D  = 64'h00000100_80000000; // L=000001 R=800000
  localparam logic [63:0] W_E  = 64'h7FFFFF00_FFFFFF00; // L=7FFFFF R=FFFFFF
  localparam logic [63:0] W_LR = 64'h00000001_FFFFFFFE; // lrclk high for b=31..62
`ifdef I2S_TX_HOLD_EN
  localparam logic [63:0] W_UR_A = W_A;
`else
  localparam logic [63:0] W_UR_A = 64'h0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk, lrclk, sdata, underrun;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) in_if ();

  i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(BD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (in_if.slave),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int urun_cyc = 0;

  always @(negedge clk) if (underrun === 1'b1) urun_cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rise();
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = bclk;
    for (int i = 0; i < 4 * BD && !ok; i++) begin
      @(posedge clk); #1;
      if (!prev && bclk) ok = 1'b1;
      prev = bclk;
    end
    if (!ok) chk("bclk_rise_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_lr_fall();
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = lrclk;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(posedge clk); #1;
      if (prev && !lrclk) ok = 1'b1;
      prev = lrclk;
    end
    if (!ok) chk("lrclk_fall_timeout", 64'(ok), 64'd1);
  endtask

  // Call positioned just after the bclk rise of b=63; returns after the next one.
  task automatic grab(output logic [63:0] sd, output logic [63:0] lr);
    sd = '0;
    lr = '0;
    for (int i = 0; i < 64; i++) begin
      wait_rise();
      sd[63-i] = sdata;
      lr[63-i] = lrclk;
    end
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(negedge clk);
      if (in_if.in_ready) ok = 1'b1;
    end
    if (!ok) chk("ready_timeout", 64'(ok), 64'd1);
    in_if.in_left  = l;
    in_if.in_right = r;
    in_if.in_valid = 1'b1;
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1, "watchdog");
  end

  logic [63:0] sd, lr;
  int lows[3];
  longint t1, t2;
  stereo_t bp_pairs[3];

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_left  = '0;
    in_if.in_right = '0;
    bp_pairs[0] = '{left: 24'h123456, right: 24'hFEDCBA};
    bp_pairs[1] = '{left: 24'h000001, right: 24'h800000};
    bp_pairs[2] = '{left: 24'h7FFFFF, right: 24'hFFFFFF};
    lows = '{-1, -1, -1};

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd0);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_in_ready", 64'(in_if.in_ready), 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rdy_before_edge", 64'(in_if.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 64'(in_if.in_ready), 64'd1);

    // First frame carries A; pair accepted before the first frame start
    send(24'h800001, 24'h7FFFFE);
    chk("rdy_drop_on_accept", 64'(in_if.in_ready), 64'd0);
    wait_rise();                      // first rise after reset is b=63
    grab(sd, lr);
    chk("frame1_data", sd, W_A);
    chk("frame1_lrclk", lr, W_LR);
    chk("frame1_no_underrun", 64'(urun_cyc), 64'd0);

    // No pair supplied: underrun frame
    grab(sd, lr);
    chk("frame2_underrun_data", sd, W_UR_A);
    chk("frame2_lrclk", lr, W_LR);
    chk("frame2_underrun_pulse", 64'(urun_cyc), 64'd1);

    // Accept exactly on the frame-start clk with empty buffer
    repeat (3) @(posedge clk); #1;
    in_if.in_left  = 24'hA5C3F0;
    in_if.in_right = 24'h0F1E2D;
    in_if.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bnd_underrun", 64'(underrun), 64'd1);
    chk("bnd_ready_low", 64'(in_if.in_ready), 64'd0);
    in_if.in_valid = 1'b0;
    grab(sd, lr);
    chk("frame3_underrun_data", sd, W_UR_A);
    grab(sd, lr);
    chk("frame4_bnd_pair", sd, W_B);
    chk("frame4_underrun_count", 64'(urun_cyc), 64'd2);

    // Backpressure: in_valid held high, data changes every clk
    fork
      begin
        grab(sd, lr);
        chk("bp_frame5", sd, W_C);
        grab(sd, lr);
        chk("bp_frame6", sd, W_D);
        grab(sd, lr);
        chk("bp_frame7", sd, W_E);
      end
      begin
        int k, low;
        logic [23:0] junk;
        k = 0; low = 0; junk = 24'h5A5A5A;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (in_if.in_ready) begin
            if (k > 0) lows[k-1] = low;
            low = 0;
            if (k == 3) break;
            in_if.in_left  = bp_pairs[k].left;
            in_if.in_right = bp_pairs[k].right;
            k++;
          end else begin
            low++;
            junk = junk + 24'h010101;
            in_if.in_left  = junk;
            in_if.in_right = ~junk;
          end
        end
        in_if.in_valid = 1'b0;
      end
    join
    chk("bp_ready_low_c", 64'(lows[0]), 64'd3);
    chk("bp_ready_low_d", 64'(lows[1]), 64'd511);
    chk("bp_ready_low_e", 64'(lows[2]), 64'd511);
    chk("bp_no_underrun", 64'(urun_cyc), 64'd2);

    // Bit clock and frame periods
    wait_rise(); t1 = $time;
    wait_rise(); t2 = $time;
    chk("bclk_period", 64'(t2 - t1), 64'd80);
    wait_lr_fall(); t1 = $time;
    wait_lr_fall(); t2 = $time;
    chk("frame_period", 64'(t2 - t1), 64'd5120);

    // Reset mid-frame at b=20, bclk=1, with another pair buffered
    wait_lr_fall();
    wait_rise();
    repeat (6) @(posedge clk);
    send(24'hFFFFFF, 24'h000000);     // loaded at the following frame start
    wait_lr_fall();
    wait_rise();                      // b=63 rise
    repeat (5) @(posedge clk);
    send(24'h123123, 24'h321321);     // sits in the buffer
    repeat (163) @(posedge clk); #1;
    chk("pre_mrst_bclk", 64'(bclk), 64'd1);
    chk("pre_mrst_sdata", 64'(sdata), 64'd1);
    chk("pre_mrst_ready", 64'(in_if.in_ready), 64'd0);
    reset = 1'b1; #1;
    chk("mrst_bclk", 64'(bclk), 64'd0);
    chk("mrst_lrclk", 64'(lrclk), 64'd0);
    chk("mrst_sdata", 64'(sdata), 64'd0);
    chk("mrst_underrun", 64'(underrun), 64'd0);
    chk("mrst_in_ready", 64'(in_if.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    urun_cyc = 0;
    reset = 1'b0; #1;
    chk("mrst_rdy_before_edge", 64'(in_if.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("mrst_rdy_after_edge", 64'(in_if.in_ready), 64'd1);
    wait_rise();
    grab(sd, lr);
    chk("post_rst_frame_zero", sd, 64'h0);
    chk("post_rst_lrclk", lr, W_LR);
    chk("post_rst_underrun", 64'(urun_cyc), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Stereo I2S transmitter that drives the codec DAC at the output end of the pedal's audio path. It mirrors the ADC-side I2S receiver.
- Accepts processed left/right sample pairs from the effect datapath through a valid/ready handshake.
- Generates BCLK and LRCLK as clock master and serialises the samples MSB-first in standard I2S format (1-BCLK data delay after each LRCLK edge).

Parameters:
SAMPLE_WIDTH, 24, bits per channel sample (two's complement); must be <= SLOT_WIDTH
SLOT_WIDTH, 32, BCLK periods per channel slot
BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_left  input  SAMPLE_WIDTH  left sample
in_right  input  SAMPLE_WIDTH  right sample
in_valid  input  1  sample pair valid
in_ready  output  1  holding buffer empty; pair accepted when in_valid && in_ready
bclk  output  1  bit clock to DAC
lrclk  output  1  word select: 0 = left, 1 = right
sdata  output  1  serial data, changes on BCLK falling edge
underrun  output  1  one-clk pulse when a frame starts with no buffered pair

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high. All state is cleared immediately on reset assertion.
  - Output reset values: bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=0 (registered).
  - Internal reset values: divider count=0, bit counter b=2*SLOT_WIDTH-1, holding buffer empty, shift registers 0.
  - in_ready rises on the first clk after reset deasserts.
  - Reset mid-frame discards the in-flight frame and the buffered pair. No partial data is resumed.
- Divider:
  - Count runs 0..BCLK_DIV-1. At terminal count, bclk toggles.
  - Falling strobe = terminal count while bclk=1. Rising strobe = terminal count while bclk=0.
  - BCLK period = 2*BCLK_DIV clk.
- Bit counter b: 0..2*SLOT_WIDTH-1. It advances on each falling strobe and wraps to 0. The wrap is the frame-start event.
- Data mapping at each falling strobe, for the new value of b:
  - sdata = left[SAMPLE_WIDTH-1-b] for b < SAMPLE_WIDTH.
  - sdata = right[SAMPLE_WIDTH-1-(b-SLOT_WIDTH)] for SLOT_WIDTH <= b < SLOT_WIDTH+SAMPLE_WIDTH.
  - sdata = 0 for all other b.
- LRCLK: lrclk = 1 for b in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], else 0. This places each LRCLK edge one BCLK before the corresponding MSB. lrclk and sdata update on the same clk edge as the bclk falling edge.
- Holding buffer (one pair):
  - in_ready = !buffer_full, registered.
  - Accept writes the buffer and drops in_ready on the next clk.
- Frame start:
  - If the buffer is full: load the frame shift registers from the buffer and empty it. in_ready rises the next clk.
  - If the buffer is empty: assert underrun for exactly that clk and load the fallback frame (see Optional Feature).
  - Simultaneous accept and frame start can only occur with the buffer empty. The frame takes the underrun path and the accepted pair goes to the buffer for the next frame.
- The first frame after reset starts 2*BCLK_DIV clk after reset release. With no pair sent in time, it underruns.
- Sample bits pass through unmodified: no rounding, no sign manipulation.

Optional Feature:
- Macro I2S_TX_HOLD_EN.
- Defined: on underrun, the frame repeats the last successfully transmitted pair (0 if none since reset).
- Undefined: on underrun, the frame transmits all-zero samples.
- The underrun pulse is identical in both builds.

Decomposition:
- audio_pkg:
  - AUDIO_SAMPLE_WIDTH = 24 and AUDIO_SLOT_WIDTH = 32 constants.
  - sample_t = logic signed [AUDIO_SAMPLE_WIDTH-1:0].
  - Packed struct stereo_t {sample_t left; sample_t right;}.
- Sub-module i2s_clkgen: divider and bclk register, outputs bclk plus fall/rise strobes. The receiver reuses it in slave-detect form later.

Test Plan:
- Reset/idle: assert reset mid-frame (b=20, bclk=1) -> same cycle bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=0; in_ready=1 one clk after release.
- Data pattern: defaults, send L=24'h800001, R=24'h7FFFFE before first frame start -> left slot sdata = 1,0×22,1,0×8; right slot = 0,1×22,0,0×8; bclk period 8 clk; frame 512 clk.
- LRCLK alignment: check lrclk rises at the falling strobe for b=31 and falls at b=63; left MSB appears at b=0, right MSB at b=32.
- Backpressure: hold in_valid=1 with changing data -> in_ready low from accept until next frame start +1 clk; each frame carries exactly the pair accepted while in_ready=1; no pair dropped or duplicated.
- Underrun: send one pair, then none -> second frame start pulses underrun for 1 clk; sdata all 0 (macro undefined) or repeats pair (I2S_TX_HOLD_EN defined).
- Boundary accept: assert in_valid exactly on the frame-start clk with buffer empty -> underrun=1 that clk; pair transmitted in the following frame.
